emu_phase_ctrl: RTL
===================

// Module: emu_phase_ctrl
// PURPOSE
//  Synthesisable run sequencer for the network emulation top level. Drives the network reset,
//  packet-source enable and sink measure window through RESET/WARMUP/MEASURE/COOLDOWN.
//  Replaces the sim-only timed initial block, so FPGA builds run identical measurement phases.
//  Sits beside packet_source/packet_sink and gates them; it never touches packet data.
// PARAMETERS
//  PORTS          `PORTS  number of network ports (width of inject/eject strobes)
//  CNT_W          32      width of phase-length inputs and cycle counters
//  RST_CYCLES     16      cycles net_rst is held after start is accepted (>=1)
//  DRAIN_TIMEOUT  4096    max DRAIN cycles before forced DONE (DRAIN_WAIT_EN only)
// PORTS
//  clk            in   1          system clock
//  rst            in   1          synchronous, active-high reset
//  start          in   1          begin run; accepted in IDLE or DONE only
//  abort          in   1          return to IDLE from any state; priority over start
//  warmup_len     in   CNT_W      WARMUP length in cycles, latched on start accept
//  measure_len    in   CNT_W      MEASURE length in cycles, latched on start accept
//  cooldown_len   in   CNT_W      COOLDOWN length in cycles, latched on start accept
//  inj_valid      in   PORTS      per-port packet accepted into network this cycle
//  ej_valid       in   PORTS      per-port packet delivered by network this cycle
//  net_rst        out  1          reset to network, sources, sink and timestamp counter
//  source_on      out  1          packet sources enabled
//  measure        out  1          sink statistics window open
//  done           out  1          run complete; held until next start, abort or rst
//  phase          out  3          phase_t encoding of current state
//  meas_cycles    out  CNT_W      cycles with measure=1 this run; saturates at all-ones
//  in_flight      out  CNT_W      injected minus ejected packets since net_rst deasserted
//  err_underflow  out  1          sticky: ejections exceeded injections; cleared on start accept
// BEHAVIOUR
//  - Clock is clk; rst is synchronous and active-high. rst forces IDLE with net_rst=1,
//    source_on=0, measure=0, done=0, meas_cycles=0, in_flight=0, err_underflow=0.
//  - Outputs are a Moore decode of the state register. No combinational path from inputs.
//  - States and outputs (net_rst/source_on/measure):
//    IDLE 1/0/0, RESET 1/0/0, WARMUP 0/1/0, MEASURE 0/1/1, COOLDOWN 0/0/1,
//    DRAIN 0/0/1, DONE 0/0/0 with done=1.
//  - IDLE|DONE + start -> RESET. Latch the three lengths and load the down-counter with RST_CYCLES.
//  - RESET lasts exactly RST_CYCLES cycles. WARMUP, MEASURE and COOLDOWN each last exactly
//    their latched length. A length of 0 skips that phase with zero cycles spent in it.
//    Chained zero lengths resolve in the same cycle.
//  - Phase exit: counter==1 at a clock edge moves to the next phase on that edge.
//  - abort in any state != IDLE -> IDLE next cycle; start in the same cycle is ignored.
//  - start outside IDLE/DONE is ignored. Length inputs changing mid-run have no effect.
//  - in_flight += popcount(inj_valid) - popcount(ej_valid) each cycle; held at 0 while net_rst=1.
//  - If the result would go negative: clamp to 0 and set err_underflow.
//  - meas_cycles increments in every cycle where measure=1 and clears on start accept.
// CONFIGURATION
//  DRAIN_WAIT_EN defined:
//    COOLDOWN expiry -> DRAIN. DRAIN -> DONE when in_flight==0 is registered, or after
//    DRAIN_TIMEOUT cycles. The timeout case asserts an extra output drain_timeout
//    (sticky, cleared on start accept).
//  DRAIN_WAIT_EN undefined:
//    COOLDOWN expiry -> DONE. The DRAIN state and drain_timeout port do not exist.
//    in_flight is still counted.
// STRUCTURE
//  - Package emu_ctrl_pkg holds:
//    typedef enum logic [2:0] phase_t {IDLE, RESET, WARMUP, MEASURE, COOLDOWN, DRAIN, DONE};
//    function popcount; localparam PHASE_W = 3.
//  - One sub-module: phase_counter (loadable CNT_W down-counter with zero/one flags, sync clear).
//    Instantiated once and shared by all timed phases.
//  - in_flight accumulator and meas_cycles live in the top module.
// TESTING
//  1. warmup=5, measure=10, cooldown=4, start pulse in IDLE:
//     net_rst high 16 cycles, then source_on 15 cycles, measure 14 cycles;
//     done=1; meas_cycles=14.
//  2. warmup=0, measure=0, cooldown=3:
//     RESET -> COOLDOWN directly; measure high 3 cycles; source_on never asserts.
//  3. abort asserted during MEASURE cycle 4, together with start:
//     IDLE next cycle; net_rst=1, measure=0; start ignored; a later start re-runs cleanly.
//  4. inj_valid=4'b1011 for 3 cycles, then ej_valid=4'b0111 for 3 cycles:
//     in_flight peaks at 9, returns to 0.
//     A further ej_valid=4'b0001 leaves in_flight=0 and sets err_underflow.
//  5. DRAIN_WAIT_EN, in_flight=2 at COOLDOWN end, one eject 7 cycles later and the last 12 cycles later:
//     DRAIN lasts until in_flight==0; then DONE with drain_timeout=0.
//  6. DRAIN_WAIT_EN, DRAIN_TIMEOUT=8, in_flight stuck at 1:
//     DONE after 8 DRAIN cycles with drain_timeout=1. start re-run clears it.

Source files
------------

// File: rtl/emu_ctrl_pkg.sv
// Shared types and helpers for the emulation run sequencer.
// PORTS may be supplied as a macro; it defaults to 4 network ports.
`ifndef PORTS
`define PORTS 4
`endif

package emu_ctrl_pkg;

    localparam int PHASE_W = 3;
    localparam int POP_W   = 64;

    typedef enum logic [PHASE_W-1:0] {
        IDLE     = 3'd0,
        RESET    = 3'd1,
        WARMUP   = 3'd2,
        MEASURE  = 3'd3,
        COOLDOWN = 3'd4,
        DRAIN    = 3'd5,
        DONE     = 3'd6
    } phase_t;

    // Strobe vectors are zero-extended to POP_W bits by the caller.
    function automatic logic [6:0] popcount(input logic [POP_W-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < POP_W; i++) begin
            c = c + {6'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/emu_phase_ctrl_counter.sv
// Loadable down-counter shared by every timed phase of the run sequencer.
// Stops at zero; one_o marks the final cycle of a phase.
module phase_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o,
    output logic             one_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/emu_phase_ctrl.sv
// Run sequencer: RESET/WARMUP/MEASURE/COOLDOWN phases gating the network, sources and sink.
// Define DRAIN_WAIT_EN to add a DRAIN phase that waits for in-flight packets (with timeout).
module emu_phase_ctrl
    import emu_ctrl_pkg::*;
#(
    parameter int PORTS         = `PORTS,
    parameter int CNT_W         = 32,
    parameter int RST_CYCLES    = 16,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] warmup_len,
    input  logic [CNT_W-1:0] measure_len,
    input  logic [CNT_W-1:0] cooldown_len,
    input  logic [PORTS-1:0] inj_valid,
    input  logic [PORTS-1:0] ej_valid,
    output logic             net_rst,
    output logic             source_on,
    output logic             measure,
    output logic             done,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] meas_cycles,
    output logic [CNT_W-1:0] in_flight,
    output logic             err_underflow
`ifdef DRAIN_WAIT_EN
    ,
    output logic             drain_timeout
`endif
);

    localparam logic [CNT_W-1:0] RST_LEN = CNT_W'(RST_CYCLES);
`ifdef DRAIN_WAIT_EN
    localparam phase_t           TAIL_PH  = DRAIN;
    localparam logic [CNT_W-1:0] TAIL_LEN = CNT_W'(DRAIN_TIMEOUT);
`else
    localparam phase_t           TAIL_PH  = DONE;
    localparam logic [CNT_W-1:0] TAIL_LEN = '0;
`endif

    phase_t           state_q, state_d;
    logic [CNT_W-1:0] warm_q, meas_len_q, cool_q;
    logic [CNT_W-1:0] meas_cnt_q;
    logic [CNT_W-1:0] in_flight_q, in_flight_d;
    logic             err_q;
    logic             under;

    logic             accept;
    logic             cnt_clr, cnt_load, cnt_zero, cnt_one, expire;
    logic [CNT_W-1:0] cnt_val;
    phase_t           nxt_ph;
    logic [CNT_W-1:0] nxt_len;

    assign accept  = (state_q == IDLE || state_q == DONE) && start && !abort;
    assign cnt_clr = rst || (abort && state_q != IDLE);
    // Zero counts as expiry too so a timed phase can never stall.
    assign expire  = cnt_one || cnt_zero;

    phase_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero),
        .one_o      (cnt_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The following non-empty timed phase; zero lengths chain through in one cycle.
    always_comb begin
        nxt_ph  = TAIL_PH;
        nxt_len = TAIL_LEN;
        if (state_q == RESET && warm_q != '0) begin
            nxt_ph  = WARMUP;
            nxt_len = warm_q;
        end else if ((state_q == RESET || state_q == WARMUP) && meas_len_q != '0) begin
            nxt_ph  = MEASURE;
            nxt_len = meas_len_q;
        end else if ((state_q == RESET || state_q == WARMUP || state_q == MEASURE)
                     && cool_q != '0) begin
            nxt_ph  = COOLDOWN;
            nxt_len = cool_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_d  = RESET;
                        cnt_load = 1'b1;
                        cnt_val  = RST_LEN;
                    end
                end
                RESET, WARMUP, MEASURE, COOLDOWN: begin
                    if (expire) begin
                        state_d  = nxt_ph;
                        cnt_load = 1'b1;
                        cnt_val  = nxt_len;
                    end
                end
`ifdef DRAIN_WAIT_EN
                DRAIN: begin
                    if (in_flight_q == '0 || expire) begin
                        state_d = DONE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        net_rst   = 1'b0;
        source_on = 1'b0;
        measure   = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE, RESET: net_rst = 1'b1;
            WARMUP:      source_on = 1'b1;
            MEASURE: begin
                source_on = 1'b1;
                measure   = 1'b1;
            end
            COOLDOWN, DRAIN: measure = 1'b1;
            DONE:        done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_q     <= '0;
            meas_len_q <= '0;
            cool_q     <= '0;
        end else if (accept) begin
            warm_q     <= warmup_len;
            meas_len_q <= measure_len;
            cool_q     <= cooldown_len;
        end
    end

    // Packet accounting: one extra bit of headroom exposes underflow.
    logic [CNT_W:0] inj_sum, ej_cnt, diff;

    assign inj_sum = {1'b0, in_flight_q} + (CNT_W+1)'(popcount(POP_W'(inj_valid)));
    assign ej_cnt  = (CNT_W+1)'(popcount(POP_W'(ej_valid)));
    assign diff    = inj_sum - ej_cnt;

    always_comb begin
        in_flight_d = in_flight_q;
        under       = 1'b0;
        if (net_rst) begin
            in_flight_d = '0;
        end else if (inj_sum < ej_cnt) begin
            in_flight_d = '0;
            under       = 1'b1;
        end else begin
            in_flight_d = diff[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_q <= '0;
            err_q       <= 1'b0;
            meas_cnt_q  <= '0;
        end else begin
            in_flight_q <= in_flight_d;
            if (accept) begin
                err_q <= 1'b0;
            end else if (under) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                meas_cnt_q <= '0;
            end else if (measure && meas_cnt_q != '1) begin
                meas_cnt_q <= meas_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef DRAIN_WAIT_EN
    logic drain_to_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_to_q <= 1'b0;
        end else if (accept) begin
            drain_to_q <= 1'b0;
        end else if (state_q == DRAIN && !abort && in_flight_q != '0 && expire) begin
            drain_to_q <= 1'b1;
        end
    end

    assign drain_timeout = drain_to_q;
`endif

    assign phase         = state_q;
    assign meas_cycles   = meas_cnt_q;
    assign in_flight     = in_flight_q;
    assign err_underflow = err_q;

endmodule
